// File: rtl/fdiv_seq.sv
// Sequential 16-bit float divider: restoring mantissa division over 9 cycles,
// followed by one normalise/pack cycle. Truncating, with zero/overflow/div-by-zero handling.
module fdiv_seq #(
    parameter int BIAS = 127
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic        busy,
    output logic        done,
    output logic [15:0] r,
    output logic        dz
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        NORM = 2'd2
    } state_t;

    localparam logic [9:0] BIAS_W = BIAS[9:0];

    state_t      state_r;
    state_t      state_s;
    logic [15:0] a_r;
    logic [15:0] b_r;
    logic        sign_r;
    logic [7:0]  mb_r;
    logic [9:0]  rem_r;
    logic [8:0]  q_r;
    logic [3:0]  cnt_r;

    logic        ge_s;
    logic [9:0]  rem_sub_s;
    logic [9:0]  e_s;
    logic [6:0]  f_s;
    logic [15:0] res_s;
    logic        dz_s;

    // Assemble a finite, normal result word.
    function automatic logic [15:0] pack_float(input logic s, input logic [7:0] e, input logic [6:0] f);
        return {s, e, f};
    endfunction

    // Next-state logic of the control FSM.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_s = DIV;
                end else begin
                    state_s = IDLE;
                end
            end
            DIV: begin
                if (cnt_r == 4'd8) begin
                    state_s = NORM;
                end else begin
                    state_s = DIV;
                end
            end
            NORM:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // Restoring step and result selection; e is a 10-bit two's-complement value.
    always_comb begin
        ge_s      = (rem_r >= {2'b00, mb_r});
        rem_sub_s = rem_r - {2'b00, mb_r};
        e_s       = {2'b00, a_r[14:7]} - {2'b00, b_r[14:7]} + BIAS_W - (q_r[8] ? 10'd0 : 10'd1);
        f_s       = q_r[8] ? q_r[7:1] : q_r[6:0];
        dz_s      = 1'b0;
        res_s     = 16'h0000;
        if (b_r[14:0] == 15'd0) begin
            dz_s  = 1'b1;
            res_s = pack_float(sign_r, 8'hFF, 7'h00);
        end else if (a_r[14:0] == 15'd0) begin
            res_s = 16'h0000;
        end else if (e_s[9] || (e_s == 10'd0)) begin
            res_s = 16'h0000;
        end else if (e_s >= 10'd255) begin
            res_s = pack_float(sign_r, 8'hFE, 7'h7F);
        end else begin
            res_s = pack_float(sign_r, e_s[7:0], f_s);
        end
    end

    // State register, datapath registers and registered outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r <= IDLE;
            a_r     <= 16'h0000;
            b_r     <= 16'h0000;
            sign_r  <= 1'b0;
            mb_r    <= 8'h00;
            rem_r   <= 10'd0;
            q_r     <= 9'd0;
            cnt_r   <= 4'd0;
            busy    <= 1'b0;
            done    <= 1'b0;
            r       <= 16'h0000;
            dz      <= 1'b0;
        end else begin
            state_r <= state_s;
            done    <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (start) begin
                        a_r    <= a;
                        b_r    <= b;
                        sign_r <= a[15] ^ b[15];
                        mb_r   <= {1'b1, b[6:0]};
                        rem_r  <= {2'b00, 1'b1, a[6:0]};
                        q_r    <= 9'd0;
                        cnt_r  <= 4'd0;
                        busy   <= 1'b1;
                    end else begin
                        busy   <= 1'b0;
                    end
                end
                DIV: begin
                    q_r   <= {q_r[7:0], ge_s};
                    rem_r <= ge_s ? {rem_sub_s[8:0], 1'b0} : {rem_r[8:0], 1'b0};
                    cnt_r <= cnt_r + 4'd1;
                end
                NORM: begin
                    r    <= res_s;
                    dz   <= dz_s;
                    done <= 1'b1;
                    busy <= 1'b0;
                end
                default: begin
                    busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fdiv_seq.sv
// Directed self-checking bench for fdiv_seq: hand-computed quotients, latency,
// busy/done handshake, ignored start while busy, back-to-back throughput and reset abort.
module tb_fdiv_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] a;
    logic [15:0] b;
    logic        busy;
    logic        done;
    logic [15:0] r;
    logic        dz;

    int compared   = 0;
    int mismatched = 0;
    int lat;
    int k;
    int extra;

    fdiv_seq #(.BIAS(127)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .r     (r),
        .dz    (dz)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        compared++;
        assert (obs === exp_v) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // Counts negedges until done is seen, bounded.
    task automatic wait_done(output int n);
        n = 0;
        while (done !== 1'b1 && n < 30) begin
            @(negedge clk);
            n++;
        end
    endtask

    // Counts done pulses over a window of cycles.
    task automatic count_dones(input int cycles, output int n);
        n = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (done === 1'b1) n++;
        end
    endtask

    task automatic run_div(input string tag, input logic [15:0] ta, input logic [15:0] tb_v,
                           input logic [15:0] er, input logic edz);
        int n;
        @(negedge clk);
        a = ta; b = tb_v; start = 1'b1;
        @(negedge clk);
        start = 1'b0; a = 16'hFFFF; b = 16'hFFFF;
        chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
        chk({tag, "_done_early"}, {31'd0, done}, 32'd0);
        wait_done(n);
        chk({tag, "_latency"}, n, 32'd10);
        chk({tag, "_r"}, {16'd0, r}, {16'd0, er});
        chk({tag, "_dz"}, {31'd0, dz}, {31'd0, edz});
        chk({tag, "_busy_at_done"}, {31'd0, busy}, 32'd0);
        @(negedge clk);
        chk({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
    endtask

    initial begin
        reset = 1'b0; start = 1'b1; a = 16'h40C0; b = 16'h4000;
        repeat (3) @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_r", {16'd0, r}, 32'd0);
        chk("rst_dz", {31'd0, dz}, 32'd0);
        start = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        chk("idle_busy", {31'd0, busy}, 32'd0);

        run_div("six_by_two", 16'h40C0, 16'h4000, 16'h4040, 1'b0);
        run_div("one_by_three", 16'h3F80, 16'h4040, 16'h3EAA, 1'b0);
        run_div("neg_one_by_two", 16'hBF80, 16'h4000, 16'hBF00, 1'b0);
        run_div("div_zero", 16'h3F80, 16'h0000, 16'h7F80, 1'b1);
        run_div("zero_dividend", 16'h0000, 16'h4000, 16'h0000, 1'b0);
        run_div("overflow", 16'h7F00, 16'h0080, 16'h7F7F, 1'b0);
        run_div("underflow", 16'h0080, 16'h7F00, 16'h0000, 1'b0);

        // start pulsed mid-DIV with new operands must be ignored
        @(negedge clk);
        a = 16'h40C0; b = 16'h4000; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        a = 16'h3F80; b = 16'h4040; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(lat);
        chk("midstart_latency", lat, 32'd6);
        chk("midstart_r", {16'd0, r}, 32'h4040);
        count_dones(15, extra);
        chk("midstart_no_extra_done", extra, 32'd0);
        chk("midstart_idle", {31'd0, busy}, 32'd0);

        // start held high: one result every 11 cycles
        @(negedge clk);
        a = 16'h40C0; b = 16'h4000; start = 1'b1;
        wait_done(lat);
        chk("hold_first_latency", lat, 32'd11);
        for (int j = 0; j < 2; j++) begin
            k = 0;
            do begin
                @(negedge clk);
                k++;
            end while (done !== 1'b1 && k < 30);
            chk("hold_period", k, 32'd11);
            chk("hold_r", {16'd0, r}, 32'h4040);
        end
        start = 1'b0;
        @(negedge clk);
        chk("hold_released_busy", {31'd0, busy}, 32'd0);

        // reset in the 5th DIV cycle aborts the divide
        @(negedge clk);
        a = 16'h40C0; b = 16'h4000; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        chk("abort_busy_before", {31'd0, busy}, 32'd1);
        reset = 1'b0; start = 1'b1; a = 16'h3F80; b = 16'h4040;
        @(negedge clk);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_done", {31'd0, done}, 32'd0);
        chk("abort_r", {16'd0, r}, 32'd0);
        chk("abort_dz", {31'd0, dz}, 32'd0);
        reset = 1'b1; start = 1'b0;
        @(negedge clk);
        chk("abort_start_ignored", {31'd0, busy}, 32'd0);
        count_dones(15, extra);
        chk("abort_no_done", extra, 32'd0);
        run_div("after_reset", 16'h40C0, 16'h4000, 16'h4040, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/fdiv_seq.md
FDIV_SEQ -- requirements
Module: fdiv_seq

Interface
REQ-001 The block SHALL have one parameter: BIAS, default 127, exponent bias of the 16-bit float format (sign [15], exponent [14:7], fraction [6:0], leading 1 implied).
REQ-002 The block SHALL have one clock and one reset: the reset is synchronous and active-low.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 reset  input  1  synchronous, active-low reset.
REQ-005 start  input  1  request to begin a divide; sampled only in IDLE.
REQ-006 a  input  16  float dividend; sampled on the accepting edge.
REQ-007 b  input  16  float divisor; sampled on the accepting edge.
REQ-008 busy  output  1  high while a divide is in progress.
REQ-009 done  output  1  single-cycle pulse marking r and dz valid.
REQ-010 r  output  16  float quotient a/b; holds its value until the next done.
REQ-011 dz  output  1  divide-by-zero flag, valid with done; holds until the next done.

Function
REQ-012 The FSM SHALL have three states: IDLE, DIV and NORM.
REQ-013 In IDLE with start=1, the accepting edge SHALL latch a, b, sign=a[15]^b[15], mantissas ma={1,a[6:0]} and mb={1,b[6:0]}, and remainder rem=ma; set iteration counter to 0; and enter DIV.
REQ-014 In DIV, each edge SHALL perform one restoring step: if rem>=mb, shift in quotient bit 1 and set rem=(rem-mb)<<1; else shift in 0 and set rem=rem<<1. rem is 10 bits.
REQ-015 DIV SHALL run exactly 9 edges, producing 9-bit q = floor(ma*256/mb), with q in [128,511], then enter NORM.
REQ-016 The NORM edge SHALL compute a 10-bit signed exponent e = a[14:7] - b[14:7] + BIAS - (q[8] ? 0 : 1) and a fraction f = q[8] ? q[7:1] : q[6:0] (truncation, no rounding).
REQ-017 In the same NORM edge, the block SHALL register r and dz, pulse done=1 for exactly one cycle, and return to IDLE.
REQ-018 Result priority (first match wins):
  - b[14:0]==0: dz=1, r={sign,8'hFF,7'h00}.
  - a[14:0]==0: dz=0, r=16'h0000.
  - e<=0: r=16'h0000.
  - e>=255: r={sign,8'hFE,7'h7F}.
  - Otherwise: r={sign,e[7:0],f}.
REQ-019 Latency SHALL be fixed for all operands: done is high in the cycle after the 10th rising edge following (and counting) the accepting edge.
REQ-020 busy SHALL rise after the accepting edge and fall on the NORM edge, in the same cycle done rises; busy and done are never both high.
REQ-021 start while busy (DIV or NORM) SHALL be ignored and SHALL NOT alter the operation in progress; changes on a/b after acceptance SHALL have no effect.
REQ-022 start held high continuously SHALL start a new divide on the first IDLE edge after done, giving back-to-back throughput of one result per 11 cycles.

Reset
REQ-023 When reset=0 at a rising edge, the block SHALL enter IDLE with busy=0, done=0, r=16'h0000, dz=0, counter=0, rem=0, regardless of state.
REQ-024 A reset in DIV or NORM SHALL abort the divide without producing done; the first start accepted after reset is released SHALL behave as from power-up.
REQ-025 start SHALL be ignored on any edge where reset=0.

Verification
REQ-026 a=16'h40C0 (6.0), b=16'h4000 (2.0), start pulse -> 10 edges later done=1, r=16'h4040, dz=0; busy low in the done cycle.
REQ-027 a=16'h3F80 (1.0), b=16'h4040 (3.0) -> r=16'h3EAA, dz=0; a=16'hBF80, b=16'h4000 -> r=16'hBF00.
REQ-028 a=16'h3F80, b=16'h0000 -> dz=1, r=16'h7F80; then a=16'h0000, b=16'h4000 -> dz=0, r=16'h0000.
REQ-029 a=16'h7F00, b=16'h0080 (e=380) -> r=16'h7F7F; a=16'h0080, b=16'h7F00 -> r=16'h0000.
REQ-030 Pulse start mid-DIV with new operands -> original result is delivered and no extra done occurs; hold start high -> done every 11 cycles.
REQ-031 Assert reset=0 during the 5th DIV cycle -> next cycle busy=0, done=0, r=0, dz=0, and no done appears; a fresh 6.0/2.0 afterwards -> r=16'h4040.
